ahb_spm: RTL
============

# ahb_spm

64-bit AHB-Lite scratchpad-memory (SPM) slave occupying the `HSEL_SPM` decoder slot; its `HREADY_SPM`/`HRESP_SPM`/`HRDATA_SPM` return path feeds the slave-to-master mux.
- Wraps a single-port synchronous SRAM behind a one-entry posted-write buffer with read forwarding.
- Reads and writes complete with zero wait states, except the one buffer-collision case defined below.
- Misaligned or oversize transfers get a two-cycle ERROR response.

## Interface
- `ADDR_W`, 16: byte-address width of the SPM (64 KiB); upper `HADDR` bits are ignored, so the SPM aliases.
- `HCLK` in 1: clock, same as the main AHB clock.
- `rst` in 1: synchronous, active-high reset.
- `HSEL` in 1: slave select from the decoder.
- `HADDR` in 64: address.
- `HWRITE` in 1: 1 = write.
- `HTRANS` in 2: IDLE/BUSY/NONSEQ/SEQ.
- `HSIZE` in 3: transfer size.
- `HBURST` in 3: ignored; each beat is handled independently.
- `HWDATA` in 64: write data, valid in the data phase.
- `HMASTLOCK` in 1: ignored.
- `HREADYIN` in 1: bus HREADY from the mux.
- `HREADY` out 1: this slave's ready.
- `HRESP` out 1: 0 = OKAY, 1 = ERROR.
- `HRDATA` out 64: read data.

## Operation
- **Address phase accept:** `HSEL & HTRANS[1] & HREADYIN`. IDLE/BUSY: OKAY, zero wait, no RAM access.
- **Error check:** `HSIZE>3` or `HADDR & ((1<<HSIZE)-1) != 0` → ERROR. No RAM access, buffer untouched.
- **Byte lanes:** little-endian, lane = `HADDR[2:0]`. Byte enables come from `HSIZE` (1/2/4/8 bytes). RAM word index = `HADDR[ADDR_W-1:3]`.
- **Write:**
  - The address phase registers word index and byte enables.
  - At the end of the data phase, `HWDATA` is captured into the write buffer (`wb_valid`, `wb_addr`, `wb_be`, `wb_data`).
- **Read:** an accepted read address phase issues the RAM read in the same cycle.
- **RAM port arbitration, per cycle:**
  - Port demand is `HSEL & HTRANS[1] & !HWRITE`, taken raw, without `HREADYIN`, to avoid a combinational loop.
  - Demand present: the read uses the port.
  - Otherwise, if `wb_valid`: the buffer drains to RAM and `wb_valid` clears.
- **Collision stall:** a write data phase with `wb_valid=1`, where the buffer is not draining this cycle (read demand present):
  - `HREADY=0` for one cycle; the buffer drains in that cycle.
  - Next cycle the write completes and the new data enters the buffer.
- **Read forwarding:** in the read data phase, `HRDATA` = RAM q. Bytes where `wb_valid & wb_addr==rd_addr & wb_be[k]` are replaced by `wb_data`. The merge uses buffer contents at the start of the cycle, so it is valid even if the buffer drains that cycle.
- **ERROR response:**
  - Cycle 1: `HREADY=0`, `HRESP=1`.
  - Cycle 2: `HREADY=1`, `HRESP=1`.
  - The buffer keeps draining during error cycles if the port is free.
- **`HRDATA` outside a read data phase:** 0.
- **Reset:**
  - Clears `wb_valid`, pending data-phase state and error state; a posted write is lost.
  - Outputs: `HREADY=1`, `HRESP=0`, `HRDATA=0`.
  - RAM contents are not reset.

## Timing
- Read: address phase cycle N, data on `HRDATA` in cycle N+1 with `HREADY=1`.
- Write: zero wait states. Data is visible to reads from the cycle after its data phase, via forwarding.
- RAM update: the first cycle with no read demand after buffering. The buffer holds at most one entry.
- Collision stall: exactly one wait state, only in a write data phase that overlaps a read address phase while the buffer is full.
- Error: exactly 2 cycles, the first with `HREADY=0`.

## Structure
- `spm_pkg`: HTRANS codes (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), HSIZE codes, `size2be(size, lane)` function, `DW=64` constant.
- Sub-module `spm_ram`: `2^(ADDR_W-3)` × 64, single port, byte-write enables, registered read (1-cycle latency).
- Everything else (phase registers, write buffer, arbiter, merge, error FSM IDLE/ERR1/ERR2) lives in `ahb_spm`.

## Test plan
- Write dword `0x0123_4567_89AB_CDEF` @0x100, one idle cycle, read @0x100 → that value; `HREADY` stays 1 throughout.
- RAM zeroed; write byte 0xA5 @0x103, then back-to-back read dword @0x100 → `0x0000_0000_A500_0000`, zero wait (forwarding).
- Back-to-back write dword 0x11 @0x0, write dword 0x22 @0x8, read @0x0 → exactly one `HREADY=0` cycle in the second write's data phase; read returns 0x11; a later read @0x8 returns 0x22.
- Word read (`HSIZE=2`) @0x102 → `HREADY=0`/`HRESP=1` then `HREADY=1`/`HRESP=1`; the next OKAY transfer proceeds normally and RAM is unchanged.
- Write 0xFF @0x200, assert `rst` during its data phase → outputs `HREADY=1`, `HRESP=0`, `HRDATA=0`; a later read @0x200 returns the prior contents.
- With `ADDR_W=16`, write 0x5A5A @0x0100, read @0x1_0100 → 0x5A5A (aliasing).

Source files
------------

// File: rtl/spm_pkg.sv
// Shared AHB encodings and byte-lane helpers for the scratchpad-memory slave.
package spm_pkg;

    localparam int DW = 64;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_t;

    typedef enum logic [1:0] {
        ERR_IDLE = 2'd0,
        ERR1     = 2'd1,
        ERR2     = 2'd2
    } err_state_t;

    function automatic logic [7:0] size2be(input logic [2:0] size, input logic [2:0] lane);
        logic [7:0] m;
        case (size)
            HSIZE_BYTE: m = 8'h01;
            HSIZE_HALF: m = 8'h03;
            HSIZE_WORD: m = 8'h0F;
            default:    m = 8'hFF;
        endcase
        return m << lane;
    endfunction

    // Low address bits that must be zero for a naturally aligned transfer.
    function automatic logic [2:0] align_mask(input logic [2:0] size);
        case (size)
            HSIZE_BYTE: return 3'b000;
            HSIZE_HALF: return 3'b001;
            HSIZE_WORD: return 3'b011;
            default:    return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/spm_ram.sv
// Single-port 64-bit SRAM with byte write enables and a registered read port.
module spm_ram
    import spm_pkg::*;
#(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    be,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int k = 0; k < 8; k++) begin
                    if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ahb_spm.sv
// AHB-Lite scratchpad slave: single-port SRAM behind a one-entry posted-write
// buffer with read forwarding, zero-wait except on a buffer/read collision.
module ahb_spm
    import spm_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic          HCLK,
    input  logic          rst,
    input  logic          HSEL,
    input  logic [63:0]   HADDR,
    input  logic          HWRITE,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic [2:0]    HBURST,
    input  logic [DW-1:0] HWDATA,
    input  logic          HMASTLOCK,
    input  logic          HREADYIN,
    output logic          HREADY,
    output logic          HRESP,
    output logic [DW-1:0] HRDATA
);

    localparam int IW = ADDR_W - 3;

    logic          active, accept, err, rd_demand, stall, drain, wr_cap;
    logic [IW-1:0] idx;
    logic [7:0]    be;
    logic          dp_read, dp_write;
    logic [IW-1:0] dp_idx;
    logic [7:0]    dp_be;
    logic          wb_valid;
    logic [IW-1:0] wb_addr;
    logic [7:0]    wb_be;
    logic [DW-1:0] wb_data;
    err_state_t    state;
    logic          ram_en, ram_we;
    logic [IW-1:0] ram_addr;
    logic [7:0]    ram_be;
    logic [DW-1:0] ram_wdata, ram_q, merged;
    logic          unused;

    assign unused = ^{HBURST, HMASTLOCK, HTRANS[0], HADDR[63:ADDR_W]};

    assign active = HSEL && HTRANS[1];
    assign accept = active && HREADYIN;
    assign err    = (HSIZE > HSIZE_DWORD) || ((HADDR[2:0] & align_mask(HSIZE)) != 3'd0);
    assign idx    = HADDR[ADDR_W-1:3];
    assign be     = size2be(HSIZE, HADDR[2:0]);

    // Read demand ignores HREADYIN so HREADY never depends on itself through the mux.
    assign rd_demand = active && !HWRITE;
    assign stall     = dp_write && wb_valid && rd_demand;
    assign drain     = wb_valid && (stall || !rd_demand);
    assign wr_cap    = dp_write && !stall;

    // Handshake: a data phase completes in the cycle HREADY=1; HRESP qualifies
    // that cycle, and an address phase is taken only when HREADYIN=1.
    assign HREADY = (state != ERR1) && !stall;
    assign HRESP  = (state != ERR_IDLE);
    assign HRDATA = dp_read ? merged : '0;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = idx;
        ram_be    = wb_be;
        ram_wdata = wb_data;
        if (drain) begin
            ram_en   = 1'b1;
            ram_we   = !rst;
            ram_addr = wb_addr;
        end else if (rd_demand) begin
            ram_en = 1'b1;
        end
    end

    // Merge uses the buffer as it stood at cycle start, even if it drains now.
    always_comb begin
        merged = ram_q;
        for (int k = 0; k < 8; k++) begin
            if (wb_valid && (wb_addr == dp_idx) && wb_be[k]) merged[8*k +: 8] = wb_data[8*k +: 8];
        end
    end

    always_ff @(posedge HCLK) begin
        if (rst) begin
            dp_read  <= 1'b0;
            dp_write <= 1'b0;
            wb_valid <= 1'b0;
            state    <= ERR_IDLE;
        end else begin
            if (HREADYIN) begin
                dp_read  <= accept && !err && !HWRITE;
                dp_write <= accept && !err && HWRITE;
                if (accept) begin
                    dp_idx <= idx;
                    dp_be  <= be;
                end
            end
            case (state)
                ERR1:    state <= ERR2;
                default: state <= (accept && err) ? ERR1 : ERR_IDLE;
            endcase
            if (wr_cap) begin
                wb_valid <= 1'b1;
                wb_addr  <= dp_idx;
                wb_be    <= dp_be;
                wb_data  <= HWDATA;
            end else if (drain) begin
                wb_valid <= 1'b0;
            end
        end
    end

    spm_ram #(.AW(IW)) u_ram (
        .clk   (HCLK),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

endmodule
